// File: rtl/mac_exec_ctrl_if.sv
// rtl/mac_exec_ctrl_if.sv - FIFO bank and MAC8 side signals of the execute sequencer
interface mac_exec_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int RW = 3 * DATA_WIDTH;

    logic                 start;
    logic [7:0]           a_empty;
    logic                 b_empty;
    logic [7:0]           a_rden;
    logic                 b_rden;
    logic                 mac_en;
    logic                 mac_clr;
    logic [7:0][RW-1:0]   c_in;
    logic [7:0][RW-1:0]   result;
    logic                 busy;
    logic                 done;
    logic [2:0]           dbg_state;

    modport master (
        input  start, a_empty, b_empty, c_in,
        output a_rden, b_rden, mac_en, mac_clr, result, busy, done, dbg_state
    );

    modport slave (
        output start, a_empty, b_empty, c_in,
        input  a_rden, b_rden, mac_en, mac_clr, result, busy, done, dbg_state
    );
endinterface

// File: rtl/mac_exec_ctrl.sv
// rtl/mac_exec_ctrl.sv - execute-phase sequencer draining the A/B FIFOs into MAC8
module mac_exec_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LEN      = 8,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_exec_ctrl_if.master bus
);
    localparam int RW  = 3 * DATA_WIDTH;
    localparam int CW  = $clog2(VEC_LEN + 1);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [CW-1:0]  RD_QUOTA   = CW'(VEC_LEN);
    localparam logic [CW-1:0]  LAST_MAC   = CW'(VEC_LEN - 1);
    localparam logic [DCW-1:0] LAST_DRAIN = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      rd_cnt_q;
    logic [CW-1:0]      mac_cnt_q;
    logic [DCW-1:0]     drain_cnt_q;
    logic               vld_q;
    logic               clr_q;
    logic               busy_q;
    logic               done_q;
    logic [7:0][RW-1:0] result_q;
    logic               rd_go;

    // A read is issued only in RUN, below the per-run quota, and only when every FIFO holds data
    assign rd_go = (state_q == S_RUN) && (rd_cnt_q < RD_QUOTA) && ~|bus.a_empty && ~bus.b_empty;

    // Sequencer: clear MAC8, feed VEC_LEN beats in lock-step, wait out the skew, capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            mac_cnt_q   <= '0;
            drain_cnt_q <= '0;
            vld_q       <= 1'b0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_CLEAR;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_q     <= 1'b0;
                    rd_cnt_q  <= '0;
                    mac_cnt_q <= '0;
                    vld_q     <= 1'b0;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    // FIFO output is registered, so a beat read now is valid for MAC8 next cycle
                    vld_q <= rd_go;
                    if (rd_go) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                    if (vld_q) begin
                        mac_cnt_q <= mac_cnt_q + 1'b1;
                        if (mac_cnt_q == LAST_MAC) begin
                            state_q     <= S_DRAIN;
                            drain_cnt_q <= '0;
                            vld_q       <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == LAST_DRAIN) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    result_q <= bus.c_in;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    clr_q   <= 1'b0;
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_rden    = {8{rd_go}};
    assign bus.b_rden    = rd_go;
    assign bus.mac_en    = vld_q;
    assign bus.mac_clr   = clr_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mac_exec_ctrl.sv
// tb/tb_mac_exec_ctrl.sv - self-checking bench for mac_exec_ctrl
module tb_mac_exec_ctrl;
    localparam int DW = 8;
    localparam int VL = 8;
    localparam int DC = 8;
    localparam int RW = 3 * DW;
    localparam int BASE_LAT = VL + DC + 3;

    typedef struct packed {
        logic [7:0][RW-1:0] res;
        logic [31:0]        lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_exec_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    mac_exec_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(VL), .DRAIN_CYCLES(DC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // environment: FIFO bank and MAC8 accumulator
    int unsigned     aq[8][$];
    int unsigned     bq[$];
    logic [DW-1:0]   a_dout[8];
    logic [DW-1:0]   b_dout;
    logic [RW-1:0]   acc[8];
    int              rel = 0;
    logic [8:0]      f_mask = '0;
    int              f_from = 0;
    int              f_len = 0;

    // monitor / model state
    logic s_rd = 1'b0, s_en = 1'b0, s_clr = 1'b0, prev_rd = 1'b0;
    logic m_idle = 1'b1;
    logic [7:0][RW-1:0] held = '0;
    exp_t exp_q[$];
    exp_t cur_e;
    int sample_edge = 0, last_lat = 0, last_done_cyc = 0;
    int done_cnt = 0, rd_total = 0;
    int reads_run = 0, en_run = 0, clr_run = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int unsigned get_a(input int mode, input int i, input int k);
        case (mode)
            1: return 1;
            3: return 255;
            4: return i + k;
            5: return (3 * i + 5 * k) & 255;
            default: return i + 1;
        endcase
    endfunction

    function automatic int unsigned get_b(input int mode, input int k);
        case (mode)
            1: return k + 1;
            3: return 255;
            4: return 2;
            5: return k + 7;
            default: return k;
        endcase
    endfunction

    // FIFO pops, MAC8 accumulation and empty flags advance just after each edge
    always @(posedge clk) begin
        logic forced;
        cyc++;
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                acc[i] = '0;
                a_dout[i] = '0;
            end
            b_dout = '0;
            rel = 0;
        end else begin
            if (s_clr) begin
                for (int i = 0; i < 8; i++) acc[i] = '0;
            end else if (s_en) begin
                for (int i = 0; i < 8; i++) acc[i] = acc[i] + a_dout[i] * b_dout;
            end
            if (s_rd) begin
                for (int i = 0; i < 8; i++) a_dout[i] = DW'(aq[i].pop_front());
                b_dout = DW'(bq.pop_front());
            end
            rel = s_clr ? 1 : rel + 1;
        end
        forced = (rel >= f_from) && (rel < f_from + f_len);
        for (int r = 0; r < 8; r++) begin
            bus.a_empty[r] = (aq[r].size() == 0) || (forced && f_mask[r]);
            bus.c_in[r] = acc[r];
        end
        bus.b_empty = (bq.size() == 0) || (forced && f_mask[8]);
    end

    // compare process: protocol rules and model results checked every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            m_idle = 1'b1;
            held = '0;
            prev_rd = 1'b0;
            s_rd = 1'b0;
            s_en = 1'b0;
            s_clr = 1'b0;
        end else begin
            s_rd = bus.b_rden;
            s_en = bus.mac_en;
            s_clr = bus.mac_clr;
            chk("rden_lockstep", bus.a_rden, {8{bus.b_rden}});
            if (s_rd) chk("rden_on_empty", {bus.a_empty, bus.b_empty}, 9'h0);
            chk("clr_en_overlap", s_clr & s_en, 1'b0);
            chk("en_follows_read", s_en, prev_rd);
            if (bus.done) begin
                done_cnt++;
                last_done_cyc = cyc;
                last_lat = cyc - sample_edge;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    cur_e = exp_q.pop_front();
                    for (int i = 0; i < 8; i++) chk($sformatf("result[%0d]", i), bus.result[i], cur_e.res[i]);
                    chk("done_latency", last_lat, cur_e.lat);
                    chk("reads_per_run", reads_run, VL);
                    chk("en_per_run", en_run, VL);
                    chk("clr_per_run", clr_run, 1);
                    held = cur_e.res;
                end
                m_idle = 1'b1;
            end
            chk("result_held", bus.result, held);
            chk("busy", bus.busy, !m_idle);
            chk("state_idle", bus.dbg_state == 3'd0, m_idle);
            reads_run += int'(s_rd);
            en_run += int'(s_en);
            clr_run += int'(s_clr);
            rd_total += int'(s_rd);
            chk("read_quota", reads_run <= VL, 1'b1);
            if (m_idle && bus.start) begin
                m_idle = 1'b0;
                sample_edge = cyc + 1;
                reads_run = 0;
                en_run = 0;
                clr_run = 0;
            end
            prev_rd = s_rd;
        end
    end

    task automatic load(input int mode, input int stall);
        exp_t e;
        e.res = '0;
        for (int k = 0; k < VL; k++) begin
            for (int i = 0; i < 8; i++) aq[i].push_back(get_a(mode, i, k));
            bq.push_back(get_b(mode, k));
        end
        for (int i = 0; i < 8; i++) begin
            int unsigned sum = 0;
            for (int k = 0; k < VL; k++) sum += get_a(mode, i, k) * get_b(mode, k);
            e.res[i] = RW'(sum);
        end
        e.lat = 32'(BASE_LAT + stall);
        exp_q.push_back(e);
    endtask

    task automatic kick();
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (done_cnt == d0) chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_reads(input int target, input int budget);
        int n = 0;
        while (rd_total < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (rd_total < target) chk("read_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int d0;
        int t1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_rden", {bus.a_rden, bus.b_rden}, 9'h0);
        chk("rst_en_clr", {bus.mac_en, bus.mac_clr}, 2'b00);
        chk("rst_result", bus.result, '0);
        chk("rst_state", bus.dbg_state, 3'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // 1: unit rows against 1..8
        load(1, 0);
        kick();
        wait_done(60);
        chk("t1_result0", bus.result[0], 24'h24);
        chk("t1_result7", bus.result[7], 24'd36);
        chk("t1_latency", last_lat, 19);

        // 2: B FIFO empty for the first 3 RUN cycles
        f_from = 1; f_len = 3; f_mask = 9'h100;
        load(1, 3);
        kick();
        wait_done(60);
        chk("t2_result3", bus.result[3], 24'h24);
        chk("t2_latency", last_lat, 22);

        // 3: full-scale words with row 5 stalling for 2 cycles
        f_from = 3; f_len = 2; f_mask = 9'h020;
        load(3, 2);
        kick();
        wait_done(60);
        f_len = 0;
        chk("t3_result3", bus.result[3], 24'h7F008);
        chk("t3_latency", last_lat, 21);

        // 4: back-to-back runs with start held through done
        t1 = rd_total;
        load(4, 0);
        bus.start = 1'b1;
        wait_reads(t1 + 8, 40);
        load(5, 0);
        wait_done(60);
        chk("t4_first_row0", bus.result[0], 24'd56);
        t1 = last_done_cyc;
        bus.start = 1'b0;
        wait_done(60);
        chk("t4_second_row0", bus.result[0], 24'd1680);
        chk("t4_done_gap", last_done_cyc - t1, 20);

        // 5: start pulses while busy are ignored
        d0 = done_cnt;
        load(6, 0);
        kick();
        repeat (4) @(posedge clk);
        #2;
        kick();
        repeat (7) @(posedge clk);
        #2;
        kick();
        wait_done(60);
        repeat (30) @(posedge clk);
        #2;
        chk("t5_done_count", done_cnt - d0, 1);
        chk("t5_row2", bus.result[2], 24'd84);

        // 6: reset after 4 reads, then a clean reloaded run
        t1 = rd_total;
        load(4, 0);
        kick();
        wait_reads(t1 + 4, 40);
        rst_n = 1'b0;
        #1;
        chk("t6_state", bus.dbg_state, 3'd0);
        chk("t6_busy", bus.busy, 1'b0);
        chk("t6_outputs", {bus.a_rden, bus.b_rden, bus.mac_en, bus.mac_clr, bus.done}, 12'h0);
        chk("t6_result_zero", bus.result, '0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) aq[i].delete();
        bq.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        load(1, 0);
        kick();
        wait_done(60);
        chk("t6_result4", bus.result[4], 24'd36);
        chk("t6_latency", last_lat, 19);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
